// File: rtl/vga_pkg.sv
// Shared VGA timing constants, the per-pixel control payload and the
// helper that derives line/frame totals from the porch/sync widths.
package vga_pkg;

   localparam int VGA_CW = 3;

   localparam int H640_ACTIVE = 640;
   localparam int H640_FP     = 16;
   localparam int H640_SYNC   = 96;
   localparam int H640_BP     = 48;
   localparam int V480_ACTIVE = 480;
   localparam int V480_FP     = 10;
   localparam int V480_SYNC   = 2;
   localparam int V480_BP     = 33;

   localparam int H800_ACTIVE = 800;
   localparam int H800_FP     = 56;
   localparam int H800_SYNC   = 120;
   localparam int H800_BP     = 64;
   localparam int V600_ACTIVE = 600;
   localparam int V600_FP     = 37;
   localparam int V600_SYNC   = 6;
   localparam int V600_BP     = 23;

   typedef struct packed {
      logic de;
      logic hs;
      logic vs;
   } vga_ctl_t;

   function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with async active-low clear; depth 0
// degenerates to a wire so a zero fetch latency costs nothing.
module vga_delay_line #(
   parameter int W = 3,
   parameter int D = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   generate
      if (D == 0) begin : g_wire
         wire unused_clk_rst = &{1'b0, clk, rst};
         assign q = d;
      end else begin : g_sr
         logic [W-1:0] sr [D];

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               for (int i = 0; i < D; i++) sr[i] <= '0;
            end else begin
               sr[0] <= d;
               for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
            end
         end

         assign q = sr[D-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: raster counters, request/strobe
// decode, fetch-latency alignment and the registered pin stage.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE  = H640_ACTIVE,
   parameter int H_FP      = H640_FP,
   parameter int H_SYNC    = H640_SYNC,
   parameter int H_BP      = H640_BP,
   parameter int V_ACTIVE  = V480_ACTIVE,
   parameter int V_FP      = V480_FP,
   parameter int V_SYNC    = V480_SYNC,
   parameter int V_BP      = V480_BP,
   parameter bit HS_POL    = 1'b0,
   parameter bit VS_POL    = 1'b0,
   parameter int CW        = VGA_CW,
   parameter int FETCH_LAT = 1,
   parameter int CNT_W     = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [3*CW-1:0]   pixel_in,
   output logic [CNT_W-1:0]  req_x,
   output logic [CNT_W-1:0]  req_y,
   output logic              req_de,
   output logic              frame_start,
   output logic              line_start,
   output logic [CW-1:0]     R,
   output logic [CW-1:0]     G,
   output logic [CW-1:0]     B,
   output logic              Hs,
   output logic              Vs,
   output logic              de
);

   localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   logic [CNT_W-1:0] col;
   logic [CNT_W-1:0] row;
   vga_ctl_t         ctl_raw;
   vga_ctl_t         ctl_d;

   // Dropping en parks the raster at 0,0 so restart always begins a fresh frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col <= '0;
         row <= '0;
      end else if (!en) begin
         col <= '0;
         row <= '0;
      end else if (col == H_LAST) begin
         col <= '0;
         row <= (row == V_LAST) ? '0 : row + 1'b1;
      end else begin
         col <= col + 1'b1;
      end
   end

   always_comb begin
      ctl_raw     = '0;
      req_x       = '0;
      req_y       = '0;
      line_start  = 1'b0;
      frame_start = 1'b0;
      if (en) begin
         req_x       = col;
         req_y       = row;
         line_start  = (col == '0);
         frame_start = (col == '0) && (row == '0);
         ctl_raw.de  = (col < H_ACT_C) && (row < V_ACT_C);
         ctl_raw.hs  = (col >= HS_START) && (col < HS_END);
         ctl_raw.vs  = (row >= VS_START) && (row < VS_END);
      end
   end

   assign req_de = ctl_raw.de;

   vga_delay_line #(
      .W ($bits(vga_ctl_t)),
      .D (FETCH_LAT)
   ) u_dly (
      .clk (clk),
      .rst (rst),
      .d   (ctl_raw),
      .q   (ctl_d)
   );

   // Colour is gated by the delayed de so stale fetch data never reaches the pins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         de        <= 1'b0;
         Hs        <= ~HS_POL;
         Vs        <= ~VS_POL;
         {R, G, B} <= '0;
      end else begin
         de        <= ctl_d.de;
         Hs        <= ctl_d.hs ? HS_POL : ~HS_POL;
         Vs        <= ctl_d.vs ? VS_POL : ~VS_POL;
         {R, G, B} <= ctl_d.de ? pixel_in : '0;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances on a shrunken raster (fetch
// latency 0/1/3, one with active-high syncs) checked against a raster model.
module tb_vga_timing_gen;

   localparam int HA = 8, HFP = 2, HSY = 3, HBP = 2, HT = 15;
   localparam int VA = 4, VFP = 1, VSY = 2, VBP = 1, VT = 8;
   localparam int FT = HT * VT;

   typedef struct packed {
      logic       de;
      logic       hs;
      logic       vs;
      logic [8:0] pix;
   } s0_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   logic [10:0] rx0, ry0, rx1, ry1, rx3, ry3;
   logic        rde0, fs0, ls0, hs0, vs0, de0;
   logic        rde1, fs1, ls1, hs1, vs1, de1;
   logic        rde3, fs3, ls3, hs3, vs3, de3;
   logic [2:0]  r0, g0, b0, r1, g1, b1, r3, g3, b3;
   logic [8:0]  pix0;
   logic [8:0]  pix1 = '0;
   logic [8:0]  f3a = '0, f3b = '0, pix3 = '0;

   always #5 clk = ~clk;

   function automatic logic [8:0] fpix(input logic [10:0] x, input logic [10:0] y);
      return {x[2:0], y[2:0], x[2:0] ^ y[2:0]};
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Fetch logic stand-ins: return garbage outside the active area.
   assign pix0 = rde0 ? fpix(rx0, ry0) : 9'h1FF;
   always @(posedge clk) pix1 <= rde1 ? fpix(rx1, ry1) : 9'h1FF;
   always @(posedge clk) begin
      f3a  <= rde3 ? fpix(rx3, ry3) : 9'h1FF;
      f3b  <= f3a;
      pix3 <= f3b;
   end

   vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
                    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
                    .HS_POL(1'b1), .VS_POL(1'b1), .CW(3), .FETCH_LAT(0), .CNT_W(11))
   dut0 (.clk(clk), .rst(rst), .en(en), .pixel_in(pix0), .req_x(rx0), .req_y(ry0),
         .req_de(rde0), .frame_start(fs0), .line_start(ls0), .R(r0), .G(g0), .B(b0),
         .Hs(hs0), .Vs(vs0), .de(de0));

   vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
                    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
                    .HS_POL(1'b0), .VS_POL(1'b0), .CW(3), .FETCH_LAT(1), .CNT_W(11))
   dut1 (.clk(clk), .rst(rst), .en(en), .pixel_in(pix1), .req_x(rx1), .req_y(ry1),
         .req_de(rde1), .frame_start(fs1), .line_start(ls1), .R(r1), .G(g1), .B(b1),
         .Hs(hs1), .Vs(vs1), .de(de1));

   vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
                    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
                    .HS_POL(1'b0), .VS_POL(1'b0), .CW(3), .FETCH_LAT(3), .CNT_W(11))
   dut3 (.clk(clk), .rst(rst), .en(en), .pixel_in(pix3), .req_x(rx3), .req_y(ry3),
         .req_de(rde3), .frame_start(fs3), .line_start(ls3), .R(r3), .G(g3), .B(b3),
         .Hs(hs3), .Vs(vs3), .de(de3));

   // Model: pos is the raster position as a linear pixel index within the frame.
   int pos = 0;
   always @(posedge clk or negedge rst) begin
      if (!rst)    pos = 0;
      else if (en) pos = (pos + 1) % FT;
      else         pos = 0;
   end

   s0_t hist [8];
   s0_t cur;
   int  cc, rr;

   initial for (int i = 0; i < 8; i++) hist[i] = '0;

   task automatic chk_s0(input string nm, input logic [10:0] rx, input logic [10:0] ry,
                         input logic rde, input logic fs, input logic ls);
      chk({nm, ".req_x"},  int'(rx),  en ? cc : 0);
      chk({nm, ".req_y"},  int'(ry),  en ? rr : 0);
      chk({nm, ".req_de"}, int'(rde), int'(cur.de));
      chk({nm, ".line_start"},  int'(ls), int'(en && cc == 0));
      chk({nm, ".frame_start"}, int'(fs), int'(en && pos == 0));
   endtask

   task automatic chk_pins(input string nm, input int lat, input bit pol,
                           input logic de_a, input logic hs_a, input logic vs_a,
                           input logic [2:0] r, input logic [2:0] g, input logic [2:0] b);
      s0_t h;
      h = hist[lat + 1];
      chk({nm, ".de"},  int'(de_a), int'(h.de));
      chk({nm, ".Hs"},  int'(hs_a), int'(h.hs ? pol : !pol));
      chk({nm, ".Vs"},  int'(vs_a), int'(h.vs ? pol : !pol));
      chk({nm, ".rgb"}, int'({r, g, b}), h.de ? int'(h.pix) : 0);
   endtask

   always @(negedge clk) begin
      cc  = pos % HT;
      rr  = pos / HT;
      cur = '0;
      if (en) begin
         cur.de  = (cc < HA) && (rr < VA);
         cur.hs  = (cc >= HA + HFP) && (cc < HA + HFP + HSY);
         cur.vs  = (rr >= VA + VFP) && (rr < VA + VFP + VSY);
         cur.pix = fpix(11'(cc), 11'(rr));
      end
      if (!rst) begin
         for (int i = 0; i < 8; i++) hist[i] = '0;
      end else begin
         for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = cur;
      end
      chk_s0("d0", rx0, ry0, rde0, fs0, ls0);
      chk_s0("d1", rx1, ry1, rde1, fs1, ls1);
      chk_s0("d3", rx3, ry3, rde3, fs3, ls3);
      chk_pins("d0", 0, 1'b1, de0, hs0, vs0, r0, g0, b0);
      chk_pins("d1", 1, 1'b0, de1, hs1, vs1, r1, g1, b1);
      chk_pins("d3", 3, 1'b0, de3, hs3, vs3, r3, g3, b3);
   end

   task automatic wait_fs(input int lim);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!fs1 && k < lim);
      chk("wait_frame_start", int'(fs1), 1);
   endtask

   task automatic wait_pos(input int x, input int y, input int lim);
      int k = 0;
      do begin
         @(posedge clk); #2;
         k++;
      end while (!(rx1 == 11'(x) && (y < 0 || ry1 == 11'(y))) && k < lim);
      chk("wait_pos", int'(rx1 == 11'(x) && (y < 0 || ry1 == 11'(y))), 1);
   endtask

   int  c_hs0, c_hs1, c_hs3, c_vs1, c_de1;
   int  e0, e1, e3;
   logic p0, p1, p3;

   initial begin
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_hs1_idle", int'(hs1), 1);
      chk("rst_vs1_idle", int'(vs1), 1);
      chk("rst_hs0_idle_pol", int'(hs0), 0);
      chk("rst_vs0_idle_pol", int'(vs0), 0);
      chk("rst_de1", int'(de1), 0);
      chk("rst_rgb3", int'({r3, g3, b3}), 0);
      chk("rst_en0_req_de", int'(rde1), 0);
      en = 1'b1;
      #1;
      chk("rst_en1_req_de", int'(rde1), 1);
      chk("rst_en1_frame_start", int'(fs1), 1);
      @(posedge clk); #2 rst = 1'b1;
      @(posedge clk); #2;

      // Full-frame measurements starting at a frame_start cycle.
      wait_fs(300);
      c_hs0 = 0; c_hs1 = 0; c_hs3 = 0; c_vs1 = 0; c_de1 = 0;
      e0 = -1; e1 = -1; e3 = -1;
      for (int n = 0; n < FT; n++) begin
         if (n > 0) @(negedge clk);
         c_hs0 += int'(hs0 == 1'b1);
         c_hs1 += int'(hs1 == 1'b0);
         c_hs3 += int'(hs3 == 1'b0);
         c_vs1 += int'(vs1 == 1'b0);
         c_de1 += int'(de1);
         if (n > 0) begin
            if (hs0 && !p0 && e0 < 0) e0 = n;
            if (!hs1 && p1 && e1 < 0) e1 = n;
            if (!hs3 && p3 && e3 < 0) e3 = n;
         end
         p0 = hs0; p1 = hs1; p3 = hs3;
      end
      @(negedge clk);
      chk("frame_start_period", int'(fs1), 1);
      chk("hs0_active_cycles", c_hs0, 24);
      chk("hs1_active_cycles", c_hs1, 24);
      chk("hs3_active_cycles", c_hs3, 24);
      chk("vs1_active_cycles", c_vs1, 30);
      chk("de1_active_cycles", c_de1, 32);
      chk("hs0_edge_offset", e0, 11);
      chk("hs1_edge_offset", e1, 12);
      chk("hs3_edge_offset", e3, 14);

      // Reset inside both sync pulses.
      wait_pos(12, 6, 300);
      rst = 1'b0;
      #1;
      chk("midrst_hs1", int'(hs1), 1);
      chk("midrst_vs1", int'(vs1), 1);
      chk("midrst_hs0", int'(hs0), 0);
      chk("midrst_de3", int'(de3), 0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("release_line_start", int'(ls1), 1);
      chk("release_req_x", int'(rx1), 0);
      repeat (2 * FT) @(posedge clk);

      // Enable dropped mid-line.
      wait_pos(4, -1, 100);
      en = 1'b0;
      repeat (50) @(posedge clk);
      #2;
      chk("en_low_de1_drained", int'(de1), 0);
      en = 1'b1;
      #1;
      chk("en_rise_frame_start", int'(fs1), 1);
      chk("en_rise_req_y", int'(ry1), 0);
      repeat (FT + 30) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
